// File: rtl/collision_monitor_pkg.sv
// Shared game definitions: FSM state encoding, screen geometry, renderer colours
// and small saturating helpers used by the collision monitor and HUD logic.
package collision_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int SCREEN_W     = 96;
    localparam int SCREEN_H     = 64;
    localparam int FRAME_PIXELS = SCREEN_W * SCREEN_H;

    // RGB565 palette shared with the sprite and HUD renderers
    localparam logic [15:0] COLOUR_BLACK  = 16'h0000;
    localparam logic [15:0] COLOUR_WHITE  = 16'hFFFF;
    localparam logic [15:0] COLOUR_RED    = 16'hF800;
    localparam logic [15:0] COLOUR_GREEN  = 16'h07E0;
    localparam logic [15:0] COLOUR_BLUE   = 16'h001F;
    localparam logic [15:0] COLOUR_YELLOW = 16'hFFE0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/collision_monitor_scan_frame_tracker.sv
// Derives new_pixel / frame_tick from the shared OLED scan index; the index is
// held for several clocks per pixel, so only index changes are reported.
module scan_frame_tracker #(
    parameter int FRAME_PIXELS = 6144,
    localparam int PIX_W = $clog2(FRAME_PIXELS)
) (
    input  logic             clock_25mhz,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pixel_index,
    output logic             new_pixel,
    output logic             frame_tick
);

    logic [PIX_W-1:0] pix_prev_reg;

    always_ff @(posedge clock_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            pix_prev_reg <= '0;
        end else begin
            pix_prev_reg <= pixel_index;
        end
    end

    // A drop in index can only be the wrap from the last pixel back to 0
    assign new_pixel  = (pixel_index != pix_prev_reg);
    assign frame_tick = new_pixel && (pixel_index < pix_prev_reg);

endmodule

// File: rtl/collision_monitor.sv
// Per-frame collision accounting: overlap count -> hits, lives, invulnerability,
// score and game-over. Optional player blink controlled by COLLISION_FLASH_EN.
module collision_monitor #(
    parameter int LIVES_INIT    = 3,
    parameter int OVERLAP_MIN   = 2,
    parameter int INVULN_FRAMES = 60,
    parameter int FRAME_PIXELS  = 6144
) (
    input  logic        clock_25mhz,
    input  logic        rst_n,
    input  logic [12:0] pixel_index,
    input  logic        is_obstacle_hitbox,
    input  logic        is_player_hitbox,
    input  logic        game_active,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        hit_pulse,
    output logic        invulnerable,
    output logic        game_over,
    output logic        flash
);
    import collision_monitor_pkg::*;

    localparam logic [2:0] LIVES_RELOAD  = 3'(LIVES_INIT);
    localparam logic [7:0] HIT_THRESHOLD = 8'(OVERLAP_MIN);
    localparam logic [7:0] INVULN_RELOAD = 8'(INVULN_FRAMES);

    logic        new_pixel;
    logic        frame_tick;
    logic        overlap_now;
    logic        frame_hit;
    logic [2:0]  lives_dec;

    game_state_t state_reg;
    logic [7:0]  overlap_cnt_reg;
    logic [7:0]  inv_cnt_reg;
    logic [2:0]  lives_reg;
    logic [15:0] score_reg;
    logic        hit_pulse_reg;
    logic        invulnerable_reg;
    logic        game_over_reg;

    scan_frame_tracker #(
        .FRAME_PIXELS(FRAME_PIXELS)
    ) u_scan_frame_tracker (
        .clock_25mhz(clock_25mhz),
        .rst_n      (rst_n),
        .pixel_index(pixel_index),
        .new_pixel  (new_pixel),
        .frame_tick (frame_tick)
    );

    assign overlap_now = is_obstacle_hitbox && is_player_hitbox;
    assign frame_hit   = (overlap_cnt_reg >= HIT_THRESHOLD);
    assign lives_dec   = lives_reg - 3'd1;

    // The wrap pixel belongs to the new frame, so it seeds the next count
    always_ff @(posedge clock_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            overlap_cnt_reg <= '0;
        end else if (!game_active || state_reg == IDLE) begin
            overlap_cnt_reg <= '0;
        end else if (frame_tick) begin
            overlap_cnt_reg <= overlap_now ? 8'd1 : 8'd0;
        end else if (new_pixel && overlap_now) begin
            overlap_cnt_reg <= sat_inc8(overlap_cnt_reg);
        end
    end

    always_ff @(posedge clock_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            lives_reg        <= LIVES_RELOAD;
            score_reg        <= '0;
            inv_cnt_reg      <= '0;
            hit_pulse_reg    <= 1'b0;
            invulnerable_reg <= 1'b0;
            game_over_reg    <= 1'b0;
        end else begin
            hit_pulse_reg <= 1'b0;
            // Losing run enable beats any frame evaluation in the same cycle
            if (!game_active) begin
                state_reg        <= IDLE;
                lives_reg        <= LIVES_RELOAD;
                score_reg        <= '0;
                inv_cnt_reg      <= '0;
                invulnerable_reg <= 1'b0;
                game_over_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= PLAY;
                    end
                    PLAY: begin
                        if (frame_tick) begin
                            if (frame_hit) begin
                                lives_reg     <= lives_dec;
                                hit_pulse_reg <= 1'b1;
                                if (lives_dec == 3'd0) begin
                                    state_reg     <= OVER;
                                    game_over_reg <= 1'b1;
                                end else begin
                                    state_reg        <= INVULN;
                                    inv_cnt_reg      <= INVULN_RELOAD;
                                    invulnerable_reg <= 1'b1;
                                end
                            end else begin
                                score_reg <= sat_inc16(score_reg);
                            end
                        end
                    end
                    INVULN: begin
                        if (frame_tick) begin
                            score_reg   <= sat_inc16(score_reg);
                            inv_cnt_reg <= inv_cnt_reg - 8'd1;
                            if (inv_cnt_reg == 8'd1) begin
                                state_reg        <= PLAY;
                                invulnerable_reg <= 1'b0;
                            end
                        end
                    end
                    OVER: begin
                        state_reg <= OVER;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign lives        = lives_reg;
    assign score        = score_reg;
    assign hit_pulse    = hit_pulse_reg;
    assign invulnerable = invulnerable_reg;
    assign game_over    = game_over_reg;

`ifdef COLLISION_FLASH_EN
    logic [1:0] flash_div_reg;
    logic       flash_reg;

    // Divider sits at 0 outside INVULN, so every window starts a fresh count
    always_ff @(posedge clock_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            flash_div_reg <= '0;
            flash_reg     <= 1'b0;
        end else if (!game_active || state_reg != INVULN) begin
            flash_div_reg <= '0;
            flash_reg     <= 1'b0;
        end else if (frame_tick) begin
            if (inv_cnt_reg == 8'd1) begin
                flash_div_reg <= '0;
                flash_reg     <= 1'b0;
            end else begin
                flash_div_reg <= flash_div_reg + 2'd1;
                if (flash_div_reg == 2'd3) begin
                    flash_reg <= ~flash_reg;
                end
            end
        end
    end

    assign flash = flash_reg;
`else
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Randomized frame-level bench for collision_monitor with a per-frame game model.
module tb_collision_monitor;

    localparam int          P             = 64;
    localparam logic [12:0] LAST          = 13'd6143;
    localparam int          LIVES_INIT    = 3;
    localparam int          OVERLAP_MIN   = 2;
    localparam int          INVULN_FRAMES = 60;

    logic        clock_25mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] pixel_index = LAST;
    logic        is_obstacle_hitbox = 1'b0;
    logic        is_player_hitbox = 1'b0;
    logic        game_active = 1'b0;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        hit_pulse;
    logic        invulnerable;
    logic        game_over;
    logic        flash;

    collision_monitor dut (
        .clock_25mhz       (clock_25mhz),
        .rst_n             (rst_n),
        .pixel_index       (pixel_index),
        .is_obstacle_hitbox(is_obstacle_hitbox),
        .is_player_hitbox  (is_player_hitbox),
        .game_active       (game_active),
        .lives             (lives),
        .score             (score),
        .hit_pulse         (hit_pulse),
        .invulnerable      (invulnerable),
        .game_over         (game_over),
        .flash             (flash)
    );

    always #20 clock_25mhz = ~clock_25mhz;

    int checks = 0;
    int passed = 0;
    int frame_no = 0;

    // Frame-level game model: 0 idle, 1 play, 2 invulnerable, 3 over
    int m_mode, m_lives, m_score, m_inv, m_pending, m_div;
    bit m_flash, m_hit;

    logic [23:0] obs_vec;
    logic        stray;

    task automatic model_reset();
        m_mode = 0; m_lives = LIVES_INIT; m_score = 0; m_inv = 0;
        m_pending = 0; m_div = 0; m_flash = 0; m_hit = 0;
    endtask

    task automatic model_tick(input bit pix0_overlap);
        m_hit = 0;
        if (m_mode == 1) begin
            if (m_pending >= OVERLAP_MIN) begin
                m_lives = m_lives - 1;
                m_hit = 1;
                if (m_lives == 0) m_mode = 3;
                else begin
                    m_mode = 2; m_inv = INVULN_FRAMES; m_div = 0; m_flash = 0;
                end
            end else if (m_score < 65535) m_score = m_score + 1;
        end else if (m_mode == 2) begin
            if (m_score < 65535) m_score = m_score + 1;
            m_inv = m_inv - 1;
            if (m_inv == 0) begin
                m_mode = 1; m_div = 0; m_flash = 0;
            end else begin
                m_div = (m_div + 1) % 4;
                if (m_div == 0) m_flash = !m_flash;
            end
        end
        m_pending = pix0_overlap ? 1 : 0;
    endtask

    function automatic logic [23:0] exp_vec();
        logic exp_flash;
`ifdef COLLISION_FLASH_EN
        exp_flash = m_flash;
`else
        exp_flash = 1'b0;
`endif
        return {3'(m_lives), 16'(m_score), m_hit, logic'(m_mode == 2),
                logic'(m_mode == 3), exp_flash, 1'b0};
    endfunction

    task automatic start_game();
        pixel_index = LAST;
        game_active = 1'b1;
        @(posedge clock_25mhz); #1;
        @(posedge clock_25mhz); #1;
        m_mode = 1; m_pending = 0; m_hit = 0;
    endtask

    // Drives one short frame (pixels 0..P-2 then the last screen index).
    // Captures outputs right after the wrap edge plus any stray hit pulse.
    task automatic run_frame(input int n_ov, input int hold, input bit abort, input int stop_at);
        bit ovv[P];
        for (int k = 0; k < P; k++) ovv[k] = (k < n_ov);
        for (int k = stop_at - 1; k > 0; k--) begin
            int j;
            bit t;
            j = $urandom_range(k, 0);
            t = ovv[k]; ovv[k] = ovv[j]; ovv[j] = t;
        end
        stray = 1'b0;
        frame_no++;
        for (int i = 0; i < stop_at; i++) begin
            pixel_index = (i == P - 1) ? LAST : 13'(i);
            if (ovv[i]) begin
                is_obstacle_hitbox = 1'b1; is_player_hitbox = 1'b1;
            end else begin
                is_obstacle_hitbox = 1'($urandom_range(1, 0));
                is_player_hitbox = is_obstacle_hitbox ? 1'b0 : 1'($urandom_range(1, 0));
            end
            if (i == 0 && abort) game_active = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clock_25mhz); #1;
                if (i == 0 && h == 0) begin
                    if (abort) model_reset();
                    else if (m_mode != 0) model_tick(ovv[0]);
                    obs_vec = {lives, score, hit_pulse, invulnerable, game_over, flash, 1'b0};
                end else begin
                    if (hit_pulse) stray = 1'b1;
                    if (h == 0 && ovv[i] && m_mode != 0 && m_pending < 255)
                        m_pending = m_pending + 1;
                end
            end
        end
        obs_vec[0] = stray;
        $display("frame %0d: overlaps=%0d hold=%0d lives=%0d score=%0d inv=%0b over=%0b",
                 frame_no, n_ov, hold, lives, score, invulnerable, game_over);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        game_active = 1'b0;
        model_reset();
        repeat (3) @(posedge clock_25mhz);
        #1;
        checks++; if (lives !== 3'd3) $display("FAIL reset_lives: got %0d want 3", lives); else passed++;
        checks++; if (score !== 16'd0) $display("FAIL reset_score: got %0d want 0", score); else passed++;
        checks++; if (hit_pulse !== 1'b0) $display("FAIL reset_hit: got %0b want 0", hit_pulse); else passed++;
        checks++; if (invulnerable !== 1'b0) $display("FAIL reset_inv: got %0b want 0", invulnerable); else passed++;
        checks++; if (game_over !== 1'b0) $display("FAIL reset_over: got %0b want 0", game_over); else passed++;
        checks++; if (flash !== 1'b0) $display("FAIL reset_flash: got %0b want 0", flash); else passed++;
        rst_n = 1'b1;
        @(posedge clock_25mhz); #1;
    endtask

    task automatic test_clean_frames();
        start_game();
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 2, 1'b0, P);
            checks++;
            if (obs_vec !== exp_vec())
                $display("FAIL clean_frame %0d: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                         frame_no, obs_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (score !== 16'd3 || lives !== 3'd3)
            $display("FAIL clean_totals: got lives=%0d score=%0d want lives=3 score=3", lives, score);
        else passed++;
    endtask

    task automatic test_min_overlap();
        int n_ov[3] = '{1, 2, 50};
        int hold[3] = '{4, 2, 1};
        for (int f = 0; f < 3; f++) begin
            run_frame(n_ov[f], hold[f], 1'b0, P);
            checks++;
            if (obs_vec !== exp_vec())
                $display("FAIL min_overlap frame %0d: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                         frame_no, obs_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (obs_vec[4] !== 1'b1 || lives !== 3'd2 || invulnerable !== 1'b1)
            $display("FAIL first_hit: got hit=%0b lives=%0d inv=%0b want hit=1 lives=2 inv=1",
                     obs_vec[4], lives, invulnerable);
        else passed++;
    endtask

    task automatic test_invuln_window();
        int score_start;
        int score_at_60;
        score_start = int'(score);
        score_at_60 = 0;
        for (int f = 1; f <= INVULN_FRAMES + 1; f++) begin
            run_frame(50, 1, 1'b0, P);
            if (f == INVULN_FRAMES) score_at_60 = int'(score);
            checks++;
            if (obs_vec !== exp_vec())
                $display("FAIL invuln_frame %0d: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                         frame_no, obs_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (score_at_60 !== score_start + INVULN_FRAMES)
            $display("FAIL invuln_score: got %0d want %0d", score_at_60, score_start + INVULN_FRAMES);
        else passed++;
        checks++;
        if (lives !== 3'd1) $display("FAIL post_window_hit: got lives=%0d want 1", lives);
        else passed++;
    endtask

    task automatic test_game_over();
        int guard;
        logic [15:0] frozen;
        guard = 0;
        while (m_mode != 3 && guard < 200) begin
            run_frame(50, 1, 1'b0, P);
            guard++;
            checks++;
            if (obs_vec !== exp_vec())
                $display("FAIL to_over frame %0d: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                         frame_no, obs_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (game_over !== 1'b1 || lives !== 3'd0)
            $display("FAIL game_over_entry: got over=%0b lives=%0d want over=1 lives=0", game_over, lives);
        else passed++;
        frozen = score;
        for (int f = 0; f < 2; f++) begin
            run_frame(50, 1, 1'b0, P);
            checks++;
            if (obs_vec !== exp_vec() || score !== frozen)
                $display("FAIL over_frozen frame %0d: got %h want %h", frame_no, obs_vec, exp_vec());
            else passed++;
        end
        game_active = 1'b0;
        @(posedge clock_25mhz); #1;
        model_reset();
        checks++;
        if (lives !== 3'd3 || score !== 16'd0 || game_over !== 1'b0 || invulnerable !== 1'b0)
            $display("FAIL over_to_idle: got lives=%0d score=%0d over=%0b want lives=3 score=0 over=0",
                     lives, score, game_over);
        else passed++;
    endtask

    task automatic test_abort_on_tick();
        start_game();
        run_frame(0, 2, 1'b0, P);
        run_frame(5, 2, 1'b0, P);
        run_frame(0, 2, 1'b1, P);
        checks++;
        if (obs_vec !== exp_vec())
            $display("FAIL abort_on_tick: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                     obs_vec, exp_vec());
        else passed++;
        checks++;
        if (obs_vec[4] !== 1'b0 || lives !== 3'd3)
            $display("FAIL abort_no_hit: got hit=%0b lives=%0d want hit=0 lives=3", obs_vec[4], lives);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        start_game();
        run_frame(0, 1, 1'b0, P);
        run_frame(3, 1, 1'b0, P);
        run_frame(0, 1, 1'b0, P);
        checks++;
        if (obs_vec !== exp_vec())
            $display("FAIL pre_reset_hit: got %h want %h", obs_vec, exp_vec());
        else passed++;
        run_frame(10, 1, 1'b0, 30);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (lives !== 3'd3 || score !== 16'd0 || hit_pulse !== 1'b0 || invulnerable !== 1'b0 ||
            game_over !== 1'b0 || flash !== 1'b0)
            $display("FAIL async_reset: got lives=%0d score=%0d hit=%0b inv=%0b over=%0b flash=%0b want 3 0 0 0 0 0",
                     lives, score, hit_pulse, invulnerable, game_over, flash);
        else passed++;
        model_reset();
        game_active = 1'b0;
        pixel_index = LAST;
        repeat (2) @(posedge clock_25mhz);
        rst_n = 1'b1;
        @(posedge clock_25mhz); #1;
    endtask

    task automatic test_random();
        int pick[5] = '{0, 1, 2, 3, 50};
        start_game();
        for (int f = 0; f < 80; f++) begin
            bit abort;
            abort = ($urandom_range(19, 0) == 0);
            run_frame(pick[$urandom_range(4, 0)], $urandom_range(3, 1), abort, P);
            checks++;
            if (obs_vec !== exp_vec())
                $display("FAIL random frame %0d: got %h want %h (lives,score,hit,inv,over,flash,stray)",
                         frame_no, obs_vec, exp_vec());
            else passed++;
            if (m_mode == 3) begin
                game_active = 1'b0;
                @(posedge clock_25mhz); #1;
                model_reset();
            end
            if (m_mode == 0) start_game();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_frames();
        test_min_overlap();
        test_invuln_window();
        test_game_over();
        test_abort_on_tick();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
